b2b_event_arbiter: RTL and testbench
====================================

# b2b_event_arbiter

Event-granular round-robin arbiter that merges `N_INPUTS` cluster FIFOs into one downstream FIFO write port. It sits between the input SpyBuffer FIFOs and a single-input consumer, such as a board2board switching lane or an output SpyBuffer. Once an input is granted, the arbiter forwards one complete event (SOE metadata word through EOE metadata word) from it without interleaving words from other inputs. It then re-arbitrates.

## Interface
Parameters:
- `DATA_WIDTH`, 65, word width including the metadata flag at bit `DATA_WIDTH-1`.
- `N_INPUTS`, 4, number of input FIFOs (≥2).
- `SEL_BITS`, `$clog2(N_INPUTS)`, width of the grant index.

Ports:
- `clock`  in  1  TP clock, nominally 200 MHz.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  permits starting new events.
- `in_data`  in  `DATA_WIDTH` ×`N_INPUTS`  FIFO read data, valid the cycle after the read.
- `in_empty`  in  1 ×`N_INPUTS`  FIFO empty flags.
- `in_rd_req`  out  1 ×`N_INPUTS`  FIFO read enables.
- `out_data`  out  `DATA_WIDTH`  word to the downstream FIFO.
- `out_wren`  out  1  downstream write enable.
- `out_almost_full`  in  1  downstream backpressure; the downstream margin is ≥2 words.
- `grant_id`  out  `SEL_BITS`  index of the current or last granted input.
- `busy`  out  1  high while in STREAM.
- `events_forwarded`  out  32  count of EOE words written.
- `protocol_error`  out  1  sticky protocol-violation flag.

## Operation
Word classification:
- SOE: bit `DATA_WIDTH-1`=1 and bit `DATA_WIDTH-2`=1.
- EOE: bit `DATA_WIDTH-1`=1 and bit `DATA_WIDTH-3`=1.
- All other words are payload.

State machine:
- States are IDLE and STREAM. Reset enters IDLE with round-robin pointer `rr`=0.
- In IDLE, when `enable`=1 and any `in_empty[i]`=0: pick the first non-empty input starting at `rr` and searching upward with wrap. Latch it into `grant_id` and go to STREAM. No read is issued in IDLE.
- In STREAM, `in_rd_req[g]` = !`in_empty[g]` & !`out_almost_full` & !`eoe_hit`. This is combinational, and only the granted index `g` is ever asserted.
- `rd_valid` is a register equal to the previous cycle's `in_rd_req[g]`.
- `eoe_hit` = `rd_valid` & (`in_data[g]` is EOE). Reading stops in the same cycle the EOE data appears, so the next event's header is never fetched.
- When `rd_valid`=1, the register stage captures `in_data[g]` into `out_data` and asserts `out_wren` for one cycle.
- On the `eoe_hit` edge: state goes to IDLE and `rr` becomes `g+1`, wrapping at `N_INPUTS`.
- `events_forwarded` increments when an EOE word is written and wraps at 2^32.

Protocol errors (each sets `protocol_error`, which is cleared only by reset):
- The first word forwarded in a grant is not SOE. The word is still forwarded.
- An SOE word appears mid-event. The word is still forwarded and the event continues.

Other behaviour:
- `enable` deasserted during STREAM: the current event completes, and no new grant is made.
- An empty granted FIFO mid-event: hold the grant indefinitely. There is no timeout.
- `out_almost_full` only gates new reads. A word already in flight is still written.
- Reset mid-event, async: in-flight words are dropped and all state clears.

## Timing
- Reset values: `in_rd_req`=0, `out_wren`=0, `out_data`=0, `grant_id`=0, `busy`=0, `events_forwarded`=0, `protocol_error`=0.
- Read issued in cycle t gives `out_wren`/`out_data` in cycle t+2: one cycle of FIFO latency plus one output register.
- Arbitration takes one cycle. If IDLE sees a non-empty input in cycle t, `busy`=1 and the first `in_rd_req` are in cycle t+1.
- Streaming sustains one word per cycle while the FIFO is non-empty and `out_almost_full`=0.
- Event-to-event gap: EOE data returns in cycle t. The state is IDLE in t+1, arbitration happens in t+1, and the next read is at t+2. That gives 2 idle read cycles per event switch.
- The `out_almost_full` rise in cycle t suppresses the read in t. At most one more word is written, in t+1.

## Test plan
- Single input 0 holds SOE, 3 payload, EOE: 5 consecutive `out_wren` starting 3 cycles after `in_empty[0]` falls, then `events_forwarded`=1, `busy`=0, and `protocol_error`=0.
- Inputs 0–3 each hold two 4-word events: output order is events from 0,1,2,3,0,1,2,3, with no interleaving within an event and `events_forwarded`=8.
- Input 1 holds event A then event B back-to-back: `in_rd_req[1]` drops in the cycle A's EOE data is visible, and B's SOE is read only after re-arbitration.
- `out_almost_full` held high for 10 cycles mid-event: no reads during the window, ≤1 trailing write, and the stream resumes with no lost or duplicated words.
- Event starting with a payload word (0x0_…): the word is forwarded and `protocol_error`=1 until `reset_n` is pulsed.
- `reset_n` asserted mid-event: all outputs are 0 immediately, and after release the next grant is input 0.

Source files
------------

// File: rtl/b2b_event_arbiter.sv
// Event-granular round-robin merge of N FIFOs into one write port; read-to-write latency 2 cycles.
// Backpressure: out_almost_full gates new reads only; an in-flight word is still written.
module b2b_event_arbiter #(
  parameter int DATA_WIDTH = 65,
  parameter int N_INPUTS   = 4,
  parameter int SEL_BITS   = $clog2(N_INPUTS)
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic                                enable,
  input  logic [N_INPUTS-1:0][DATA_WIDTH-1:0] in_data,
  input  logic [N_INPUTS-1:0]                 in_empty,
  output logic [N_INPUTS-1:0]                 in_rd_req,
  output logic [DATA_WIDTH-1:0]               out_data,
  output logic                                out_wren,
  input  logic                                out_almost_full,
  output logic [SEL_BITS-1:0]                 grant_id,
  output logic                                busy,
  output logic [31:0]                         events_forwarded,
  output logic                                protocol_error
);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                state_q, state_d;
  logic [SEL_BITS-1:0]   rr_q, rr_d;
  logic [SEL_BITS-1:0]   grant_q, grant_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  first_q, first_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_wren_q, out_wren_d;
  logic [31:0]           events_q, events_d;
  logic                  perr_q, perr_d;

  logic [DATA_WIDTH-1:0] g_data;
  logic                  g_soe, g_eoe, eoe_hit;
  logic                  pick_vld;
  logic [SEL_BITS-1:0]   pick_idx;

  function automatic logic [SEL_BITS-1:0] wrap_add(input logic [SEL_BITS-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_INPUTS) s = s - N_INPUTS;
    return SEL_BITS'(s);
  endfunction

  assign g_data = in_data[grant_q];
  assign g_soe  = g_data[DATA_WIDTH-1] & g_data[DATA_WIDTH-2];
  assign g_eoe  = g_data[DATA_WIDTH-1] & g_data[DATA_WIDTH-3];

  // Walk downward so the candidate nearest rr is the last one written and wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = N_INPUTS - 1; k >= 0; k--) begin
      if (!in_empty[wrap_add(rr_q, k)]) begin
        pick_vld = 1'b1;
        pick_idx = wrap_add(rr_q, k);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    grant_d    = grant_q;
    first_d    = first_q;
    in_rd_req  = '0;
    out_wren_d = 1'b0;
    out_data_d = out_data_q;
    events_d   = events_q;
    perr_d     = perr_q;
    eoe_hit    = rd_valid_q & g_eoe;

    case (state_q)
      IDLE: begin
        if (enable && pick_vld) begin
          state_d = STREAM;
          grant_d = pick_idx;
          first_d = 1'b1;
        end
      end
      STREAM: begin
        // Stopping on the EOE data itself keeps the next event's header in its FIFO.
        in_rd_req[grant_q] = !in_empty[grant_q] & !out_almost_full & !eoe_hit;
        if (eoe_hit) begin
          state_d = IDLE;
          rr_d    = wrap_add(grant_q, 1);
        end
      end
      default: state_d = IDLE;
    endcase

    rd_valid_d = in_rd_req[grant_q];

    if (rd_valid_q) begin
      out_wren_d = 1'b1;
      out_data_d = g_data;
      if (g_eoe) events_d = events_q + 32'd1;
      if (first_q) begin
        first_d = 1'b0;
        if (!g_soe) perr_d = 1'b1;
      end else if (g_soe) begin
        perr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      rr_q       <= '0;
      grant_q    <= '0;
      rd_valid_q <= 1'b0;
      first_q    <= 1'b0;
      out_data_q <= '0;
      out_wren_q <= 1'b0;
      events_q   <= '0;
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      grant_q    <= grant_d;
      rd_valid_q <= rd_valid_d;
      first_q    <= first_d;
      out_data_q <= out_data_d;
      out_wren_q <= out_wren_d;
      events_q   <= events_d;
      perr_q     <= perr_d;
    end
  end

  assign out_data         = out_data_q;
  assign out_wren         = out_wren_q;
  assign grant_id         = grant_q;
  assign busy             = (state_q == STREAM);
  assign events_forwarded = events_q;
  assign protocol_error   = perr_q;

endmodule

// File: tb/tb_b2b_event_arbiter.sv
// Bench for b2b_event_arbiter: FIFO models per input, event-level round-robin reference model.
module tb_b2b_event_arbiter;
  localparam int DW = 65;
  localparam int N  = 4;
  localparam int SB = 2;
  typedef logic [DW-1:0] word_t;

  logic             clock = 1'b0;
  logic             reset_n = 1'b1;
  logic             enable = 1'b0;
  logic [N-1:0][DW-1:0] in_data = '0;
  logic [N-1:0]     in_empty = '1;
  logic [N-1:0]     in_rd_req;
  logic [DW-1:0]    out_data;
  logic             out_wren;
  logic             out_almost_full = 1'b0;
  logic [SB-1:0]    grant_id;
  logic             busy;
  logic [31:0]      events_forwarded;
  logic             protocol_error;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  word_t fq[N][$];
  word_t mq[N][$];
  word_t exp_q[$];
  word_t wr_data[$];
  int wr_cyc[$];
  logic [N-1:0] rd_hist[$];
  int m_rr = 0;
  int m_events = 0;

  b2b_event_arbiter #(.DATA_WIDTH(DW), .N_INPUTS(N), .SEL_BITS(SB)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable),
    .in_data(in_data), .in_empty(in_empty), .in_rd_req(in_rd_req),
    .out_data(out_data), .out_wren(out_wren), .out_almost_full(out_almost_full),
    .grant_id(grant_id), .busy(busy), .events_forwarded(events_forwarded),
    .protocol_error(protocol_error)
  );

  always #5 clock = ~clock;

  // Input FIFOs: a read at an edge presents the popped word during the following cycle.
  always @(posedge clock) begin
    rd_hist.push_back(in_rd_req);
    for (int i = 0; i < N; i++) begin
      if (in_rd_req[i] && fq[i].size() > 0) begin
        word_t w;
        w = fq[i].pop_front();
        in_data[i] <= w;
      end
    end
    cyc = cyc + 1;
  end

  always @(negedge clock) begin
    for (int i = 0; i < N; i++) in_empty[i] = (fq[i].size() == 0);
    if (out_wren) begin
      wr_data.push_back(out_data);
      wr_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  function automatic word_t mk(input logic [2:0] f);
    logic [63:0] r;
    r = {$urandom, $urandom};
    return {f, r[61:0]};
  endfunction

  task automatic put(input int i, input word_t w);
    fq[i].push_back(w);
    mq[i].push_back(w);
  endtask

  // kind 0: well formed; 1: first word is payload; 2: extra SOE as first payload word
  task automatic push_event(input int i, input int npay, input int kind);
    put(i, (kind == 1) ? mk(3'b000) : mk(3'b110));
    for (int p = 0; p < npay; p++) put(i, (kind == 2 && p == 0) ? mk(3'b110) : mk(3'b000));
    put(i, mk(3'b101));
  endtask

  // Whole events, one at a time, taken from the first non-empty input at or after the pointer.
  task automatic model_drain();
    bit found;
    int idx;
    word_t w;
    do begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        idx = (m_rr + k) % N;
        if (!found && mq[idx].size() > 0) begin
          found = 1;
          do begin
            w = mq[idx].pop_front();
            exp_q.push_back(w);
          end while (!(w[DW-1] && w[DW-3]) && mq[idx].size() > 0);
          if (w[DW-1] && w[DW-3]) m_events++;
          m_rr = (idx + 1) % N;
        end
      end
    end while (found);
  endtask

  task automatic compare_stream(input string tag);
    model_drain();
    check({tag, "_nwords"}, wr_data.size(), exp_q.size());
    for (int j = 0; j < wr_data.size() && j < exp_q.size(); j++)
      check({tag, "_word"}, wr_data[j], exp_q[j]);
    check({tag, "_events"}, events_forwarded, m_events);
    wr_data.delete();
    wr_cyc.delete();
    exp_q.delete();
  endtask

  function automatic bit fq_pending();
    for (int i = 0; i < N; i++) if (fq[i].size() > 0) return 1;
    return 0;
  endfunction

  task automatic wait_drain(input string tag, input bit rand_af);
    int n = 0;
    while ((fq_pending() || busy) && n < 3000) begin
      if (rand_af) out_almost_full = ($urandom_range(0, 3) == 0);
      tick(1);
      n++;
    end
    out_almost_full = 1'b0;
    check({tag, "_drained"}, n < 3000, 1);
    tick(6);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      fq[i].delete();
      mq[i].delete();
    end
    tick(2);
    wr_data.delete();
    wr_cyc.delete();
    exp_q.delete();
    m_rr = 0;
    m_events = 0;
    reset_n = 1'b1;
    tick(1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k0, w, c, nrd, ntr, n;
    #1 reset_n = 1'b0;
    #2;
    check("rst_wren", out_wren, 0);
    check("rst_data", out_data, 0);
    check("rst_grant", grant_id, 0);
    check("rst_busy", busy, 0);
    check("rst_events", events_forwarded, 0);
    check("rst_perr", protocol_error, 0);
    check("rst_rdreq", in_rd_req, 0);
    tick(2);
    reset_n = 1'b1;
    enable = 1'b1;
    tick(2);

    // Single 5-word event on input 0
    k0 = cyc;
    push_event(0, 3, 0);
    tick(14);
    check("t1_first_wr_lat", (wr_cyc.size() > 0) ? wr_cyc[0] - k0 : -1, 3);
    check("t1_span", (wr_cyc.size() > 0) ? wr_cyc[wr_cyc.size()-1] - wr_cyc[0] : -1, 4);
    check("t1_busy", busy, 0);
    check("t1_perr", protocol_error, 0);
    compare_stream("t1");

    // Two 4-word events on every input
    do_reset();
    enable = 1'b0;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) push_event(i, 2, 0);
    tick(1);
    enable = 1'b1;
    wait_drain("t2", 0);
    check("t2_events8", events_forwarded, 8);
    check("t2_perr", protocol_error, 0);
    compare_stream("t2");

    // Back-to-back events on input 1
    do_reset();
    push_event(1, 2, 0);
    push_event(1, 2, 0);
    wait_drain("t3", 0);
    if (wr_cyc.size() >= 8) begin
      w = wr_cyc[3];
      check("t3_rd_at_eoe", rd_hist[w-1][1], 0);
      check("t3_rd_idle", rd_hist[w][1], 0);
      check("t3_rd_resume", rd_hist[w+1][1], 1);
      check("t3_gap", wr_cyc[4] - w, 3);
    end else begin
      check("t3_nwr", wr_cyc.size(), 8);
    end
    compare_stream("t3");

    // almost_full window of 10 cycles mid-event
    do_reset();
    push_event(2, 14, 0);
    tick(6);
    c = cyc;
    out_almost_full = 1'b1;
    tick(10);
    out_almost_full = 1'b0;
    wait_drain("t4", 0);
    nrd = 0;
    for (int k = c; k < c + 10; k++) if (rd_hist[k] != 0) nrd++;
    ntr = 0;
    for (int j = 0; j < wr_cyc.size(); j++) if (wr_cyc[j] >= c + 1 && wr_cyc[j] <= c + 11) ntr++;
    check("t4_reads_in_window", nrd, 0);
    check("t4_trailing_le1", ntr <= 1, 1);
    compare_stream("t4");

    // Protocol errors
    do_reset();
    push_event(0, 2, 1);
    wait_drain("t5", 0);
    check("t5_perr", protocol_error, 1);
    compare_stream("t5");
    tick(10);
    check("t5_sticky", protocol_error, 1);
    do_reset();
    check("t5_cleared", protocol_error, 0);
    push_event(3, 2, 2);
    wait_drain("t5b", 0);
    check("t5b_perr", protocol_error, 1);
    compare_stream("t5b");

    // Reset mid-event
    do_reset();
    push_event(1, 1, 0);
    wait_drain("t6a", 0);
    compare_stream("t6a");
    push_event(2, 20, 0);
    tick(8);
    reset_n = 1'b0;
    #1;
    check("t6_wren", out_wren, 0);
    check("t6_data", out_data, 0);
    check("t6_busy", busy, 0);
    check("t6_grant", grant_id, 0);
    check("t6_events", events_forwarded, 0);
    check("t6_rdreq", in_rd_req, 0);
    for (int i = 0; i < N; i++) begin
      fq[i].delete();
      mq[i].delete();
    end
    tick(2);
    wr_data.delete();
    wr_cyc.delete();
    m_rr = 0;
    m_events = 0;
    reset_n = 1'b1;
    tick(1);
    push_event(3, 1, 0);
    push_event(0, 1, 0);
    tick(3);
    check("t6_next_grant", grant_id, 0);
    check("t6_next_busy", busy, 1);
    wait_drain("t6b", 0);
    compare_stream("t6b");

    // Randomized batches with random backpressure
    do_reset();
    for (int b = 0; b < 8; b++) begin
      enable = 1'b0;
      for (int i = 0; i < N; i++) begin
        n = $urandom_range(0, 3);
        for (int e = 0; e < n; e++) push_event(i, $urandom_range(0, 5), 0);
      end
      tick(1);
      enable = 1'b1;
      wait_drain("rnd", 1);
      compare_stream("rnd");
    end
    check("rnd_perr", protocol_error, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
